mdu_iterative: RTL and testbench

- Iterative unsigned multiply/divide unit for the multi-cycle MIPS datapath.
- Sits directly downstream of the control unit, alongside the ALU.
- Consumes the control unit's 6-bit aluop codes _MULTU (6'b010001) and _DIVU (6'b010000), together with the A/B operand registers.
- Holds the architectural HI/LO registers read by MFHI/MFLO and written by MTHI/MTLO.
- Uses a radix-2, one-bit-per-cycle algorithm: shift-add for multiply, restoring for divide.

---
 rtl/mdu_iterative.sv | 171 +++++++++++++++++
 tb/tb_mdu_iterative.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative radix-2 unsigned multiply/divide unit owning the architectural HI/LO registers.
// MULTU uses shift-add, DIVU uses restoring division; one bit per clock, WIDTH clocks per op.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for MULTU/DIVU start; MTHI/MTLO writes accepted
// S_CALC | one iteration per clock, count runs WIDTH-1 down to 0
// S_DONE | result sits in hi/lo, done pulses for this single cycle
module mdu_iterative #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  OP_MULTU = 6'b010001,
    parameter logic [5:0]  OP_DIVU  = 6'b010000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             op_div_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic             start_ok;
    logic             start_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_nx;
    logic [WIDTH-1:0] div_lo_nx;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign start_ok  = start && ((aluop == OP_MULTU) || (aluop == OP_DIVU));
    assign start_div = (aluop == OP_DIVU);

    // Multiply: acc_hi/acc_lo form the 2*WIDTH product register, opnd_q is the multiplicand.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    // Divide: acc_hi is the remainder, acc_lo the quotient, opnd_q the divisor.
    // The remainder always stays below the divisor, so WIDTH bits hold it between
    // iterations; only the shifted trial value needs the extra bit.
    always_comb begin
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_hi_nx = div_ok ? div_diff : div_shift[WIDTH-1:0];
        div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ok};
    end

    assign iter_hi = op_div_q ? div_hi_nx : mul_hi_nx;
    assign iter_lo = op_div_q ? div_lo_nx : mul_lo_nx;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_div_q <= 1'b0;
            opnd_q   <= '0;
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        op_div_q <= start_div;
                        opnd_q   <= start_div ? b : a;
                        acc_hi_q <= '0;
                        acc_lo_q <= start_div ? a : b;
                        count_q  <= CNT_W'(WIDTH - 1);
                        dbz_q    <= 1'b0;
                    end else begin
                        if (hi_wr) begin
                            hi_q <= wdata;
                        end
                        if (lo_wr) begin
                            lo_q <= wdata;
                        end
                    end
                end
                S_CALC: begin
                    acc_hi_q <= iter_hi;
                    acc_lo_q <= iter_lo;
                    count_q  <= count_q - 1'b1;
                    if (count_q == '0) begin
                        hi_q <= iter_hi;
                        lo_q <= iter_lo;
                        if (op_div_q && (opnd_q == '0)) begin
                            dbz_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: latency, MULTU/DIVU results, divide-by-zero,
// ignored requests while busy, MTHI/MTLO writes and mid-operation reset.
module tb_mdu_iterative;

    localparam logic [5:0] OP_MULTU = 6'b010001;
    localparam logic [5:0] OP_DIVU  = 6'b010000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total  = 0;
    int passed = 0;

    mdu_iterative #(
        .WIDTH    (32),
        .OP_MULTU (OP_MULTU),
        .OP_DIVU  (OP_DIVU)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .aluop       (aluop),
        .a           (a),
        .b           (b),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Samples after edge E0+k; done is expected at k=32, the 33rd cycle after the accept edge.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = -1;
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] opa, input logic [31:0] opb,
                          output int lat, output int busy_cycles, output logic dbz_accept);
        start = 1'b1;
        aluop = op;
        a     = opa;
        b     = opb;
        tick();
        start = 1'b0;
        aluop = 6'b000000;
        a     = $urandom;
        b     = $urandom;
        dbz_accept = div_by_zero;
        wait_done(lat, busy_cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          bcy;
        int          n_done;
        logic        dbz_acc;
        logic [31:0] res_hi;
        logic [31:0] res_lo;
        logic [31:0] hi_mid;

        rst   = 1'b1;
        start = 1'b0;
        aluop = 6'b000000;
        a     = '0;
        b     = '0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wdata = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dbz",  32'(div_by_zero), 32'd0);
        check("reset hi",   hi, 32'h0);
        check("reset lo",   lo, 32'h0);
        rst = 1'b0;
        tick();

        // MULTU max*max
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcy, dbz_acc);
        check("multu max latency", 32'(lat), 32'd32);
        check("multu max busy cycles", 32'(bcy), 32'd32);
        check("multu max hi", hi, 32'hFFFF_FFFE);
        check("multu max lo", lo, 32'h0000_0001);
        check("multu max dbz", 32'(div_by_zero), 32'd0);
        tick();
        check("done single pulse", 32'(done), 32'd0);
        check("idle after done busy", 32'(busy), 32'd0);

        // DIVU 100/7
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcy, dbz_acc);
        check("divu 100/7 latency", 32'(lat), 32'd32);
        check("divu 100/7 lo", lo, 32'd14);
        check("divu 100/7 hi", hi, 32'd2);
        check("divu 100/7 dbz", 32'(div_by_zero), 32'd0);
        tick();

        // DIVU msb/1
        run_op(OP_DIVU, 32'h8000_0000, 32'd1, lat, bcy, dbz_acc);
        check("divu msb/1 lo", lo, 32'h8000_0000);
        check("divu msb/1 hi", hi, 32'h0);
        tick();

        // DIVU by zero keeps the restoring result
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, lat, bcy, dbz_acc);
        check("divu by 0 latency", 32'(lat), 32'd32);
        check("divu by 0 lo", lo, 32'hFFFF_FFFF);
        check("divu by 0 hi", hi, 32'h1234_5678);
        check("divu by 0 dbz", 32'(div_by_zero), 32'd1);
        tick();
        check("dbz sticky in idle", 32'(div_by_zero), 32'd1);

        run_op(OP_MULTU, 32'd3, 32'd5, lat, bcy, dbz_acc);
        check("dbz cleared on accept", 32'(dbz_acc), 32'd0);
        check("multu 3*5 lo", lo, 32'd15);
        check("multu 3*5 hi", hi, 32'd0);
        tick();

        // MULTU 6*7 with start and MTHI requests while busy
        start = 1'b1;
        aluop = OP_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        tick();
        start  = 1'b0;
        a      = 32'd100;
        b      = 32'd100;
        n_done = 0;
        lat    = -1;
        res_hi = 32'hX;
        res_lo = 32'hX;
        hi_mid = 32'hX;
        for (int k = 0; k < 46; k++) begin
            if (done === 1'b1) begin
                n_done++;
                if (lat < 0) begin
                    lat    = k;
                    res_hi = hi;
                    res_lo = lo;
                end
            end
            if (k == 11) hi_mid = hi;
            start = (k == 5 || k == 20);
            hi_wr = (k == 10);
            wdata = (k == 10) ? 32'h0000_DEAD : 32'h0;
            tick();
        end
        start = 1'b0;
        hi_wr = 1'b0;
        check("busy mthi ignored", hi_mid, 32'h0);
        check("busy starts done count", 32'(n_done), 32'd1);
        check("busy starts latency", 32'(lat), 32'd32);
        check("multu 6*7 hi", res_hi, 32'h0);
        check("multu 6*7 lo", res_lo, 32'd42);

        // MTHI/MTLO in IDLE
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        check("mthi+mtlo hi", hi, 32'hA5A5_A5A5);
        check("mthi+mtlo lo", lo, 32'hA5A5_A5A5);
        lo_wr = 1'b1;
        wdata = 32'h5A5A_5A5A;
        tick();
        lo_wr = 1'b0;
        check("mtlo only hi", hi, 32'hA5A5_A5A5);
        check("mtlo only lo", lo, 32'h5A5A_5A5A);

        // unsupported aluop is ignored
        start = 1'b1;
        aluop = 6'b000000;
        a     = 32'd1;
        b     = 32'd1;
        tick();
        start = 1'b0;
        check("bad aluop busy", 32'(busy), 32'd0);
        tick();
        check("bad aluop busy later", 32'(busy), 32'd0);
        check("bad aluop done", 32'(done), 32'd0);
        check("bad aluop lo kept", lo, 32'h5A5A_5A5A);

        // valid start wins over same-cycle MTHI/MTLO
        start = 1'b1;
        aluop = OP_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wdata = 32'h1111_1111;
        tick();
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        aluop = 6'b000000;
        check("collision busy", 32'(busy), 32'd1);
        check("collision hi dropped", hi, 32'hA5A5_A5A5);
        check("collision lo dropped", lo, 32'h5A5A_5A5A);
        wait_done(lat, bcy);
        check("collision latency", 32'(lat), 32'd32);
        check("multu 2*3 lo", lo, 32'd6);
        check("multu 2*3 hi", hi, 32'd0);
        tick();

        // reset in the middle of a DIVU
        start = 1'b1;
        aluop = OP_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        tick();
        start = 1'b0;
        aluop = 6'b000000;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset hi", hi, 32'h0);
        check("mid reset lo", lo, 32'h0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            tick();
        end
        check("no activity after reset", 32'(n_done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
